// File: rtl/alu_seq.sv
// Multi-cycle RV32I/RV32M execute unit: single-cycle integer ops plus
// iterative shift-add multiply and restoring divide behind valid/ready handshakes.
module alu_seq #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 8,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [19:0]     imm,
  input  logic [PC_W-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_val,
  output logic            busy
);

  localparam int          CNT_W    = $clog2(XLEN) + 1;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  F7_BASE  = 7'b0000000;
  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [6:0]  F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0]       lo_q, lo_d;     // product low half / quotient
  logic [XLEN-1:0]       opa_q, opa_d;   // multiplicand / divisor magnitude
  logic [XLEN-1:0]       rs1_q, rs1_d;
  logic [2:0]            f3_q, f3_d;
  logic                  a_neg_q, a_neg_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       rd_q, rd_d;

  // Single-cycle datapath, evaluated on the raw inputs at the accept edge.
  logic signed [11:0]    imm12;
  logic signed [31:0]    imm32;
  logic [XLEN-1:0]       imm_i, imm_u, op_b, alu_res;
  logic [SHAMT_W-1:0]    shamt;
  logic [6:0]            alt;
  logic                  is_r, is_m, plain;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_res = '0;
    imm12   = imm[11:0];
    imm32   = {imm, 12'b0};
    imm_i   = XLEN'(imm12);
    imm_u   = XLEN'(imm32);
    is_r    = (opcode == OP_R);
    is_m    = is_r && (funct7 == F7_MULDIV);
    op_b    = is_r ? rs2_val : imm_i;
    shamt   = op_b[SHAMT_W-1:0];
    alt     = is_r ? funct7 : imm[11:5];
    plain   = !is_r || (funct7 == F7_BASE);
    if (opcode == OP_R || opcode == OP_I) begin
      case (funct3)
        3'b000: begin
          if (is_r && alt == F7_ALT) alu_res = rs1_val - op_b;
          else if (plain)            alu_res = rs1_val + op_b;
        end
        3'b001: if (alt == F7_BASE) alu_res = rs1_val << shamt;
        3'b010: if (plain) alu_res = XLEN'($signed(rs1_val) < $signed(op_b));
        3'b011: if (plain) alu_res = XLEN'(rs1_val < op_b);
        3'b100: if (plain) alu_res = rs1_val ^ op_b;
        3'b101: begin
          if (alt == F7_BASE)     alu_res = rs1_val >> shamt;
          else if (alt == F7_ALT) alu_res = XLEN'($signed(rs1_val) >>> shamt);
        end
        3'b110: if (plain) alu_res = rs1_val | op_b;
        default: if (plain) alu_res = rs1_val & op_b;
      endcase
    end else if (opcode == OP_LUI) begin
      alu_res = imm_u;
    end else if (opcode == OP_AUIPC) begin
      alu_res = XLEN'(pc) + imm_u;
    end
  end

  // Operand signedness and magnitudes for the M group.
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = rs1_val[XLEN-1] &
            ((!funct3[2] && funct3 != 3'b011) || (funct3[2] && !funct3[0]));
    b_sgn = rs2_val[XLEN-1] &
            ((!funct3[2] && !funct3[1]) || (funct3[2] && !funct3[0]));
    a_mag = a_sgn ? -rs1_val : rs1_val;
    b_mag = b_sgn ? -rs2_val : rs2_val;
  end

  // One iteration step for each engine, plus the final sign fix-up.
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, rem, m_res;
  logic              div_zero;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opa_q};
    prod      = {acc_q, lo_q};
    prod_fix  = neg_q ? -prod : prod;
    quot      = neg_q ? -lo_q : lo_q;
    rem       = a_neg_q ? -acc_q : acc_q;
    div_zero  = (opa_q == '0);
    case (f3_q)
      3'b000:                m_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: m_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:        m_res = div_zero ? '1 : quot;
      default:               m_res = div_zero ? rs1_q : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    rs1_d   = rs1_q;
    f3_d    = f3_q;
    a_neg_d = a_neg_q;
    neg_d   = neg_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_m) begin
            state_d = CALC;
            cnt_d   = '0;
            acc_d   = '0;
            rs1_d   = rs1_val;
            f3_d    = funct3;
            a_neg_d = a_sgn;
            neg_d   = a_sgn ^ b_sgn;
            lo_d    = funct3[2] ? a_mag : b_mag;
            opa_d   = funct3[2] ? b_mag : a_mag;
          end else begin
            state_d = DONE;
            rd_d    = alu_res;
          end
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = DONE;
          cnt_d   = '0;
          rd_d    = m_res;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (f3_q[2]) begin
            // Restoring divide: keep the trial subtraction only if it did not borrow.
            acc_d = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
          end else begin
            acc_d = mul_sum[XLEN:1];
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the datapath registers are reset too, so a discarded operation leaves no residue.
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      rs1_q   <= '0;
      f3_q    <= '0;
      a_neg_q <= 1'b0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      rs1_q   <= rs1_d;
      f3_q    <= f3_d;
      a_neg_q <= a_neg_d;
      neg_q   <= neg_d;
      rd_q    <= rd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign rd_val    = rd_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit instance with hand-computed vectors and
// a 64-bit instance with directed vectors plus random M ops against a wide-math model.
module tb_alu_seq;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F0 = 7'h00, FA = 7'h20, FM = 7'h01;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [19:0] imm;
  logic [7:0]  pc;
  logic [31:0] rs1_val, rs2_val, rd_val;

  alu_seq #(.XLEN(32), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct7(funct7), .funct3(funct3), .imm(imm), .pc(pc),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid),
    .out_ready(out_ready), .rd_val(rd_val), .busy(busy)
  );

  // 64-bit instance
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic [19:0] w_imm;
  logic [7:0]  w_pc;
  logic [63:0] w_rs1, w_rs2, w_rd;

  alu_seq #(.XLEN(64), .PC_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode(w_opcode), .funct7(w_funct7), .funct3(w_funct3), .imm(w_imm), .pc(w_pc),
    .rs1_val(w_rs1), .rs2_val(w_rs2), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .rd_val(w_rd), .busy(w_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one op on the 32-bit unit; optionally stall the consumer or poke in_valid while busy.
  task automatic op32(input string tag, input logic [6:0] opc, input logic [6:0] f7,
                      input logic [2:0] f3, input logic [19:0] im, input logic [7:0] p,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                      input int exp_lat, input int hold, input bit poke);
    int          lat;
    logic [31:0] held;
    bit          stable;
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; opcode = opc; funct7 = f7; funct3 = f3; imm = im; pc = p;
    rs1_val = a; rs2_val = b;
    @(posedge clk); #1;
    in_valid = 1'b0; opcode = OP_R; funct7 = F0; funct3 = 3'b000;
    rs1_val = 32'hDEADBEEF; rs2_val = 32'h12345678; imm = 20'hFFFFF; pc = 8'hFF;
    check({tag, "/busy"}, 64'(busy), 64'(exp_lat != 0));
    if (poke) in_valid = 1'b1;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/rd_val"}, 64'(rd_val), 64'(exp));
    if (hold > 0) begin
      held = rd_val;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || rd_val !== held) stable = 1'b0;
      end
      check({tag, "/hold_stable"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/after_hs"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  task automatic op64(input string tag, input logic [6:0] opc, input logic [6:0] f7,
                      input logic [2:0] f3, input logic [19:0] im, input logic [7:0] p,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                      input int exp_lat);
    int lat;
    w_in_valid = 1'b1; w_opcode = opc; w_funct7 = f7; w_funct3 = f3; w_imm = im; w_pc = p;
    w_rs1 = a; w_rs2 = b;
    @(posedge clk); #1;
    w_in_valid = 1'b0; w_rs1 = '1; w_rs2 = '1; w_imm = '0;
    lat = 0;
    while (!w_out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/rd_val"}, w_rd, exp);
    w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_out_ready = 1'b0;
  endtask

  function automatic logic [63:0] m_ref64(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub, p;
    logic signed [63:0]  qa, qb;
    sa = $signed(a); sb = $signed(b);
    ua = {64'd0, a}; ub = {64'd0, b};
    qa = a; qb = b;
    case (f3)
      3'd0: begin p = sa * sb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * $signed(ub); return p[127:64]; end
      3'd3: begin p = ua * ub; return p[127:64]; end
      3'd4: begin
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return qa / qb;
      end
      3'd5: return (b == 64'd0) ? '1 : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        return qa % qb;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf3;
    logic [63:0] ra, rb;
    int          saw;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; opcode = '0; funct7 = '0; funct3 = '0;
    imm = '0; pc = '0; rs1_val = '0; rs2_val = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_opcode = '0; w_funct7 = '0; w_funct3 = '0;
    w_imm = '0; w_pc = '0; w_rs1 = '0; w_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset32/flags", {61'd0, out_valid, busy, in_ready}, 64'b001);
    check("reset32/rd_val", 64'(rd_val), 64'd0);
    check("reset64/flags", {61'd0, w_out_valid, w_busy, w_in_ready}, 64'b001);

    // Single-cycle integer ops
    op32("add",   OP_R, F0, 3'b000, 20'h0, 8'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0);
    op32("sub",   OP_R, FA, 3'b000, 20'h0, 8'h0, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0);
    op32("sra",   OP_R, FA, 3'b101, 20'h0, 8'h0, 32'hF0000000, 32'd4, 32'hFF000000, 0, 0, 0);
    op32("sra36", OP_R, FA, 3'b101, 20'h0, 8'h0, 32'h80000000, 32'd36, 32'hF8000000, 0, 0, 0);
    op32("srl",   OP_R, F0, 3'b101, 20'h0, 8'h0, 32'hF0000000, 32'd4, 32'h0F000000, 0, 0, 0);
    op32("sll",   OP_R, F0, 3'b001, 20'h0, 8'h0, 32'h1, 32'd31, 32'h80000000, 0, 0, 0);
    op32("slt",   OP_R, F0, 3'b010, 20'h0, 8'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0);
    op32("sltu_eq", OP_R, F0, 3'b011, 20'h0, 8'h0, 32'd5, 32'd5, 32'h0, 0, 0, 0);
    op32("sltu",  OP_R, F0, 3'b011, 20'h0, 8'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0);
    op32("xor",   OP_R, F0, 3'b100, 20'h0, 8'h0, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, 0, 0);
    op32("or",    OP_R, F0, 3'b110, 20'h0, 8'h0, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, 0, 0);
    op32("and",   OP_R, F0, 3'b111, 20'h0, 8'h0, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0, 0);
    op32("addi",  OP_I, F0, 3'b000, 20'h00FFF, 8'h0, 32'd5, 32'h0, 32'd4, 0, 0, 0);
    op32("sltiu", OP_I, F0, 3'b011, 20'h00FFF, 8'h0, 32'd5, 32'h0, 32'h1, 0, 0, 0);
    op32("slti",  OP_I, F0, 3'b010, 20'h00FFF, 8'h0, 32'hFFFFFFFE, 32'h0, 32'h1, 0, 0, 0);
    op32("xori",  OP_I, F0, 3'b100, 20'h00FFF, 8'h0, 32'h000000FF, 32'h0, 32'hFFFFFF00, 0, 0, 0);
    op32("slli",  OP_I, F0, 3'b001, 20'h00001, 8'h0, 32'd3, 32'h0, 32'd6, 0, 0, 0);
    op32("srai",  OP_I, F0, 3'b101, 20'h00404, 8'h0, 32'h80000000, 32'h0, 32'hF8000000, 0, 0, 0);
    op32("lui",   OP_LUI, F0, 3'b000, 20'h12345, 8'h0, 32'h0, 32'h0, 32'h12345000, 0, 0, 0);
    op32("auipc", OP_AUIPC, F0, 3'b000, 20'h00001, 8'h10, 32'h0, 32'h0, 32'h00001010, 0, 0, 0);
    op32("unsup_opc", 7'b0000011, F0, 3'b000, 20'h0, 8'h0, 32'h5, 32'h5, 32'h0, 0, 0, 0);
    op32("lui2",  OP_LUI, F0, 3'b000, 20'hABCDE, 8'h0, 32'h0, 32'h0, 32'hABCDE000, 0, 0, 0);
    op32("unsup_f7", OP_R, FA, 3'b111, 20'h0, 8'h0, 32'h5, 32'h5, 32'h0, 0, 0, 0);

    // Multiply / divide, each XLEN+1 cycles
    op32("mul",    OP_R, FM, 3'b000, 20'h0, 8'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 0, 0);
    op32("mulh",   OP_R, FM, 3'b001, 20'h0, 8'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 33, 0, 0);
    op32("mulhu",  OP_R, FM, 3'b011, 20'h0, 8'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0, 0);
    op32("mulhsu", OP_R, FM, 3'b010, 20'h0, 8'h0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 0, 0);
    op32("div_neg", OP_R, FM, 3'b100, 20'h0, 8'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0, 0);
    op32("rem_neg", OP_R, FM, 3'b110, 20'h0, 8'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0, 0);
    op32("div_nd",  OP_R, FM, 3'b100, 20'h0, 8'h0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, 0, 0);
    op32("rem_nd",  OP_R, FM, 3'b110, 20'h0, 8'h0, 32'd7, 32'hFFFFFFFE, 32'h1, 33, 0, 0);
    op32("div_z",   OP_R, FM, 3'b100, 20'h0, 8'h0, 32'd5, 32'd0, 32'hFFFFFFFF, 33, 0, 0);
    op32("remu_z",  OP_R, FM, 3'b111, 20'h0, 8'h0, 32'd5, 32'd0, 32'd5, 33, 0, 0);
    op32("div_ovf", OP_R, FM, 3'b100, 20'h0, 8'h0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 0, 0);
    op32("rem_ovf", OP_R, FM, 3'b110, 20'h0, 8'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33, 0, 0);

    // Handshake: consumer stall, and in_valid pulsed while busy
    op32("divu_hold", OP_R, FM, 3'b101, 20'h0, 8'h0, 32'd100, 32'd7, 32'd14, 33, 10, 0);
    op32("remu_poke", OP_R, FM, 3'b111, 20'h0, 8'h0, 32'd100, 32'd7, 32'd2, 33, 0, 1);
    op32("add_hold",  OP_R, F0, 3'b000, 20'h0, 8'h0, 32'd40, 32'd2, 32'd42, 0, 4, 0);

    // 64-bit directed
    op64("w_add",   OP_R, F0, 3'b000, 20'h0, 8'h0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 0);
    op64("w_sra36", OP_R, FA, 3'b101, 20'h0, 8'h0, 64'h80000000_00000000, 64'd36, 64'hFFFFFFFF_F8000000, 0);
    op64("w_lui",   OP_LUI, F0, 3'b000, 20'h80000, 8'h0, 64'h0, 64'h0, 64'hFFFFFFFF_80000000, 0);
    op64("w_auipc", OP_AUIPC, F0, 3'b000, 20'h80000, 8'h10, 64'h0, 64'h0, 64'hFFFFFFFF_80000010, 0);
    op64("w_mulhu", OP_R, FM, 3'b011, 20'h0, 8'h0, '1, '1, 64'hFFFFFFFF_FFFFFFFE, 65);
    op64("w_div_ovf", OP_R, FM, 3'b100, 20'h0, 8'h0, 64'h80000000_00000000, '1, 64'h80000000_00000000, 65);
    op64("w_rem_z", OP_R, FM, 3'b110, 20'h0, 8'h0, 64'hFFFFFFFF_FFFFFFF3, 64'h0, 64'hFFFFFFFF_FFFFFFF3, 65);

    // 64-bit random M ops against the wide-arithmetic model
    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      case (i % 4)
        2:       rb = 64'($urandom_range(1, 9));
        3:       rb = 64'd0;
        default: rb = {$urandom, $urandom};
      endcase
      op64($sformatf("w_rand%0d_f%0d", i, rf3), OP_R, FM, rf3, 20'h0, 8'h0, ra, rb,
           m_ref64(rf3, ra, rb), 65);
    end

    // Reset in the middle of a divide discards it
    check("pre_rst/rd_nonzero", 64'(rd_val != 32'd0), 64'd1);
    in_valid = 1'b1; opcode = OP_R; funct7 = FM; funct3 = 3'b100;
    rs1_val = 32'd1000; rs2_val = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_div/busy", 64'(busy), 64'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid/flags", {61'd0, out_valid, busy, in_ready}, 64'b001);
    check("rst_mid/rd_val", 64'(rd_val), 64'd0);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) saw++;
    end
    check("rst_mid/no_stale", 64'(saw), 64'd0);
    op32("post_rst_add", OP_R, F0, 3'b000, 20'h0, 8'h0, 32'd1, 32'd2, 32'd3, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
